// File: rtl/pdm_byte_packer.sv
// PDM capture front end: divides the system clock down to the microphone bit clock,
// packs synchronized PDM samples MSB-first into bytes and buffers them in a FWFT FIFO.
module pdm_byte_packer #(
  parameter int CLK_DIV    = 40,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  output logic                        pdm_clk,
  input  logic                        pdm_data,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        overflow,
  output logic [15:0]                 drop_count,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic          sync_p0, sync_p1;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_idx;
  logic [6:0]    shift;
  logic [7:0]    byte_p2;
  logic          vld_p2;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          sample, full, wr_en, rd_en, drop;

  // Stage p0/p1: two-flop synchronizer for the asynchronous microphone data
  always_ff @(posedge clk) begin
    sync_p0 <= pdm_data;
    sync_p1 <= sync_p0;
  end

  // Divider, bit clock and MSB-first packing
  assign sample = en && (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      pdm_clk <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      pdm_clk <= (div_cnt < DIV_HALF);
      if (sample) begin
        shift   <= {shift[5:0], sync_p1};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // Stage p2: completed byte held for one cycle ahead of the FIFO write
  always_ff @(posedge clk) begin
    if (rst) vld_p2 <= 1'b0;
    else     vld_p2 <= sample && (bit_idx == 3'd7);
  end

  always_ff @(posedge clk) begin
    if (sample && (bit_idx == 3'd7)) byte_p2 <= {shift, sync_p1};
  end

  // Full is judged on the registered level, so a pop in the same cycle never makes room.
  assign full     = (level == FULL_LVL);
  assign wr_en    = vld_p2 && !full;
  assign drop     = vld_p2 && full;
  assign tx_valid = (level != '0);
  assign rd_en    = tx_valid && tx_ready;
  assign tx_data  = tx_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= byte_p2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= sat_inc16(drop_count);
      end
    end
  end

endmodule

// File: tb/tb_pdm_byte_packer.sv
// Directed bench for pdm_byte_packer: bit clock shape, byte packing, overflow,
// drain ordering, enable restart and mid-run reset.
module tb_pdm_byte_packer;

  logic        clk = 1'b0;
  logic        rst, en, pdm_data, tx_ready;
  logic        pdm_clk, tx_valid, overflow;
  logic [7:0]  tx_data;
  logic [15:0] drop_count;
  logic [4:0]  level;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          pops  = 0;
  logic [7:0]  pat_base = 8'h00;
  int          pat_step = 0;

  pdm_byte_packer #(.CLK_DIV(40), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .en(en), .pdm_clk(pdm_clk), .pdm_data(pdm_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .overflow(overflow), .drop_count(drop_count), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Byte number bi of the current capture stream
  function automatic logic [7:0] gen(input int bi);
    return pat_base ^ 8'(bi * pat_step);
  endfunction

  // Each bit is held for a whole 40-cycle window aligned to the capture start
  task automatic set_pdm();
    logic [7:0] b;
    int bp;
    b = gen(cyc / 320);
    bp = 7 - ((cyc / 40) % 8);
    pdm_data = b[bp];
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      set_pdm();
    end
  endtask

  task automatic start_capture(input logic [7:0] base, input int stp);
    en = 1'b0;
    step(2);
    pat_base = base;
    pat_step = stp;
    en  = 1'b1;
    cyc = 0;
    set_pdm();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pdm_data = 1'b0; tx_ready = 1'b1;
    step(3);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_drop_count", 32'(drop_count), 0);
    chk("rst_pdm_clk", 32'(pdm_clk), 0);
    rst = 1'b0;

    // Constant ones: clock shape and 0xFF bytes every 320 cycles
    start_capture(8'hFF, 0);
    chk("pdm_clk_c0", 32'(pdm_clk), 0);
    step(1);   chk("pdm_clk_c1", 32'(pdm_clk), 1);
    step(19);  chk("pdm_clk_c20", 32'(pdm_clk), 1);
    step(1);   chk("pdm_clk_c21", 32'(pdm_clk), 0);
    step(19);  chk("pdm_clk_c40", 32'(pdm_clk), 0);
    step(1);   chk("pdm_clk_c41", 32'(pdm_clk), 1);
    step(279); chk("ff_valid_c320", 32'(tx_valid), 0);
    step(1);
    chk("ff_valid_c321", 32'(tx_valid), 1);
    chk("ff_data_c321", 32'(tx_data), 32'h0000_00FF);
    chk("ff_level_c321", 32'(level), 1);
    step(1);   chk("ff_valid_c322", 32'(tx_valid), 0);
    step(318); chk("ff_valid_c640", 32'(tx_valid), 0);
    step(1);
    chk("ff_valid_c641", 32'(tx_valid), 1);
    chk("ff_data_c641", 32'(tx_data), 32'h0000_00FF);
    chk("ff_overflow", 32'(overflow), 0);

    // Bit order 1,0,1,1,0,0,1,0
    start_capture(8'hB2, 0);
    step(320); chk("b2_valid_c320", 32'(tx_valid), 0);
    step(1);
    chk("b2_valid_c321", 32'(tx_valid), 1);
    chk("b2_data", 32'(tx_data), 32'h0000_00B2);

    // 20 bytes with no reader: 16 kept, 4 dropped, then drained in order
    start_capture(8'h11, 29);
    tx_ready = 1'b0;
    step(5440);
    chk("ovf_level_c5440", 32'(level), 16);
    chk("ovf_flag_c5440", 32'(overflow), 0);
    step(1);
    chk("ovf_flag_c5441", 32'(overflow), 1);
    chk("ovf_drop_c5441", 32'(drop_count), 1);
    chk("ovf_head_hold", 32'(tx_data), 32'h0000_0011);
    step(960);
    chk("ovf_level_c6401", 32'(level), 16);
    chk("ovf_drop_c6401", 32'(drop_count), 4);
    chk("ovf_flag_c6401", 32'(overflow), 1);
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", 32'(tx_valid), 1);
      chk("drain_data", 32'(tx_data), 32'(gen(i)));
      step(1);
    end
    chk("drain_empty_valid", 32'(tx_valid), 0);
    chk("drain_empty_level", 32'(level), 0);

    // Ready toggling while a write lands at level 15
    start_capture(8'h5A, 51);
    tx_ready = 1'b0;
    step(5120);
    chk("tog_level_c5120", 32'(level), 15);
    pops = 0;
    for (int k = 0; k < 80; k++) begin
      tx_ready = (cyc < 5160) ? ((cyc % 2) == 0) : 1'b1;
      if (tx_valid && tx_ready) begin
        chk("tog_data", 32'(tx_data), 32'(gen(pops)));
        pops++;
      end
      chk("tog_level_max", 32'(level <= 5'd16), 1);
      if (cyc == 5121) chk("tog_level_c5121", 32'(level), 15);
      step(1);
    end
    chk("tog_pops", 32'(pops), 16);
    chk("tog_level_end", 32'(level), 0);
    chk("tog_valid_end", 32'(tx_valid), 0);
    chk("tog_drop_hold", 32'(drop_count), 4);

    // Enable dropped after 5 bits of an all-ones byte, restart with 0x3C
    start_capture(8'hFF, 0);
    step(210);
    chk("en_pdm_clk_high", 32'(pdm_clk), 1);
    en = 1'b0;
    step(1); chk("en_low_pdm_clk_a", 32'(pdm_clk), 0);
    step(5); chk("en_low_pdm_clk_b", 32'(pdm_clk), 0);
    chk("en_low_valid", 32'(tx_valid), 0);
    start_capture(8'h3C, 0);
    step(320); chk("en_restart_c320", 32'(tx_valid), 0);
    step(1);
    chk("en_restart_valid", 32'(tx_valid), 1);
    chk("en_restart_data", 32'(tx_data), 32'h0000_003C);

    // Reset with 10 bytes buffered and overflow sticky
    start_capture(8'hA5, 7);
    tx_ready = 1'b0;
    step(3201);
    chk("prerst_level", 32'(level), 10);
    chk("prerst_overflow", 32'(overflow), 1);
    rst = 1'b1;
    step(1);
    chk("midrst_tx_valid", 32'(tx_valid), 0);
    chk("midrst_level", 32'(level), 0);
    chk("midrst_overflow", 32'(overflow), 0);
    chk("midrst_drop_count", 32'(drop_count), 0);
    chk("midrst_pdm_clk", 32'(pdm_clk), 0);
    chk("midrst_tx_data", 32'(tx_data), 0);
    rst = 1'b0;
    en  = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pdm_byte_packer.md
# pdm_byte_packer

Capture stage ahead of the UART transmitter in the PDM streaming path. Generates the microphone bit clock from the 120 MHz system clock, samples the 1-bit PDM stream, packs 8 samples per byte MSB-first, and buffers the bytes in a small FIFO. The FIFO drains through a valid/ready byte interface into the 4 Mbaud UART TX. Overflow is counted, never stalls capture.

## Interface
- CLK_DIV, 40: system clocks per PDM clock period; even, ≥4 (120 MHz / 40 = 3 MHz PDM = 375 kB/s, under the 400 kB/s UART budget)
- FIFO_DEPTH, 16: byte FIFO entries; power of two, 2..256
- clk  in  1  system clock (PLL output, 120 MHz); one clock domain
- rst  in  1  synchronous, active-high reset
- en  in  1  capture enable; low holds capture idle
- pdm_clk  out  1  microphone bit clock, registered
- pdm_data  in  1  microphone data, asynchronous to clk
- tx_data  out  8  head-of-FIFO byte (first-word-fall-through)
- tx_valid  out  1  FIFO non-empty
- tx_ready  in  1  UART TX accepts tx_data this cycle
- overflow  out  1  sticky: a byte was dropped since reset
- drop_count  out  16  dropped bytes, saturates at 16'hFFFF
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Reset: div_cnt=0, bit_idx=0, shift=0, FIFO empty; pdm_clk=0, tx_valid=0, tx_data=0, overflow=0, drop_count=0, level=0.
- pdm_data passes a 2-flop synchronizer before use.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps while en=1. pdm_clk register = 1 when div_cnt < CLK_DIV/2, else 0 (rises on wrap to 0).
- Sample point: cycle with div_cnt == CLK_DIV-1 (end of low phase, just before rising edge). Synchronized bit shifts in: shift <= {shift[6:0], bit}; bit_idx increments mod 8.
- Byte complete: the sample with bit_idx==7 forms byte {shift[6:0], bit}; first sampled bit is bit 7.
- Write: byte written to FIFO in the cycle after its completing sample if level < FIFO_DEPTH (level evaluated before any same-cycle read; no write-through-on-full). Otherwise byte discarded, overflow<=1, drop_count increments unless saturated. Packing continues regardless.
- Read: pop when tx_valid && tx_ready. tx_ready ignored while tx_valid=0. tx_data stable while tx_valid=1 and no pop.
- Simultaneous write and pop, not full: level unchanged, order preserved.
- en=0: div_cnt, bit_idx, shift cleared; pdm_clk=0; partial byte discarded; FIFO keeps draining; overflow/drop_count hold. en rising restarts at div_cnt=0 with a fresh byte.
- rst mid-operation: everything returns to reset values next cycle, FIFO contents lost.
- Pointers: log2(FIFO_DEPTH)-bit, natural wrap; level is the explicit occupancy counter.

## Timing
- pdm_clk period CLK_DIV cycles, 50% duty; first rising edge 1 cycle after en rises (div_cnt 0).
- Input-to-sample latency: 2 cycles of synchronizer; value sampled at div_cnt==CLK_DIV-1 is pdm_data as of 2 cycles earlier.
- Byte latency: completing sample at cycle S, FIFO write at S+1, tx_valid=1 and tx_data valid from S+2 when FIFO was empty.
- Pop at cycle P: next entry on tx_data at P+1; tx_valid drops at P+1 if last entry.
- level and overflow update on the write/pop cycle edge; drop_count on the discard edge.
- Steady state: one byte per 8*CLK_DIV = 320 cycles.

## Test plan
- Reset then en=1, pdm_data constant 1, tx_ready=1 -> pdm_clk period 40 cycles, 20 high; first tx_data=8'hFF at 2 cycles after 8th sample; one byte per 320 cycles; overflow=0.
- Drive pattern 1,0,1,1,0,0,1,0 aligned to sample points -> tx_data=8'hB2.
- tx_ready=0, run 20 bytes, FIFO_DEPTH=16 -> level=16, overflow=1, drop_count=4; release tx_ready -> first 16 bytes out in capture order.
- tx_ready toggled every cycle near full while writes land -> no loss, no duplicates, level never exceeds 16.
- en dropped after 5 bits, re-raised -> partial bits discarded, next byte built from 8 fresh samples, pdm_clk low while en=0.
- rst asserted with 10 bytes buffered and overflow set -> next cycle tx_valid=0, level=0, overflow=0, drop_count=0, pdm_clk=0.
